// File: rtl/phase_seq_pkg.sv
// Shared types and defaults for the phase sequencer.
package phase_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GAP   = 2'd2,
    ST_FAULT = 2'd3
  } phase_seq_state_t;

  localparam int DEFAULT_NUM_PHASES  = 4;
  localparam int DEFAULT_WDOG_CYCLES = 210_000_000;
  localparam int WDOG_W              = 28;

endpackage

// File: rtl/phase_sequencer_rise.sv
// Registers a level input and flags its 0->1 transitions as single-cycle events.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/phase_sequencer.sv
// Steps the interval timer through NUM_PHASES timed phases per started sequence.
// Optional stuck-timer watchdog enabled by defining PHASE_SEQ_WATCHDOG_EN.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES  = DEFAULT_NUM_PHASES,
  parameter int PHASE_W     = $clog2(NUM_PHASES),
  parameter int WDOG_CYCLES = DEFAULT_WDOG_CYCLES
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               done_signal,
  output logic               enable,
  output logic [PHASE_W-1:0] phase,
  output logic               busy,
  output logic               seq_done,
  output logic               fault
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  if (NUM_PHASES < 2 || NUM_PHASES > 16 || WDOG_CYCLES < 2 ||
      WDOG_CYCLES > (1 << WDOG_W)) begin : g_bad_cfg
    $error("phase_sequencer: illegal parameter set");
  end

  phase_seq_state_t   state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               seq_done_q, seq_done_d;
  logic               expiry;

  rise_detect u_rise (
    .clk    (clock),
    .rst_n  (reset_n),
    .sig_i  (done_signal),
    .rise_o (expiry)
  );

`ifdef PHASE_SEQ_WATCHDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              fault_q, fault_d;
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    seq_done_d = 1'b0;
`ifdef PHASE_SEQ_WATCHDOG_EN
    wdog_d     = wdog_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
`ifdef PHASE_SEQ_WATCHDOG_EN
          wdog_d  = '0;
`endif
        end
      end
      ST_RUN: begin
        if (expiry) begin
          if (phase_q == LAST_PHASE) begin
            state_d    = ST_IDLE;
            phase_d    = '0;
            seq_done_d = 1'b1;
          end else begin
            state_d = ST_GAP;
            phase_d = phase_q + PHASE_W'(1);
          end
`ifdef PHASE_SEQ_WATCHDOG_EN
          wdog_d = '0;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = ST_FAULT;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
`endif
        end
      end
      // One idle cycle lets the timer counter restart from zero.
      ST_GAP: begin
        state_d = ST_RUN;
`ifdef PHASE_SEQ_WATCHDOG_EN
        wdog_d  = '0;
`endif
      end
      default: ;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      phase_d    = '0;
      seq_done_d = 1'b0;
`ifdef PHASE_SEQ_WATCHDOG_EN
      wdog_d     = '0;
`endif
    end

    enable_d = (state_d == ST_RUN);
    busy_d   = (state_d != ST_IDLE);
`ifdef PHASE_SEQ_WATCHDOG_EN
    fault_d  = (state_d == ST_FAULT);
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      enable_q   <= enable_d;
      busy_q     <= busy_d;
      seq_done_q <= seq_done_d;
    end
  end

`ifdef PHASE_SEQ_WATCHDOG_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign enable   = enable_q;
  assign phase    = phase_q;
  assign busy     = busy_q;
  assign seq_done = seq_done_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer with a 20-cycle interval timer model.
module tb_phase_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       done_signal;
  logic       enable;
  logic [1:0] phase;
  logic       busy;
  logic       seq_done;
  logic       fault;

  int tests_run = 0;
  int tests_failed = 0;

  logic        tim_en = 1'b0;
  logic        done_force = 1'b0;
  logic        done_model = 1'b0;
  int unsigned tim_cnt = 0;

  phase_sequencer #(.NUM_PHASES(3), .WDOG_CYCLES(50)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .done_signal (done_signal),
    .enable      (enable),
    .phase       (phase),
    .busy        (busy),
    .seq_done    (seq_done),
    .fault       (fault)
  );

  always #5 clock = ~clock;

  // Timer model: one-cycle done after 20 consecutive enable-high cycles.
  always @(posedge clock) begin
    if (tim_en && enable) begin
      tim_cnt    <= tim_cnt + 1;
      done_model <= (tim_cnt == 19);
    end else begin
      tim_cnt    <= 0;
      done_model <= 1'b0;
    end
  end

  assign done_signal = tim_en ? done_model : done_force;

  task automatic start_seq();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic do_abort();
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    tests_run += 5;
    if (enable !== 1'b0)   begin tests_failed++; $display("FAIL reset_enable got %b want 0", enable); end
    if (phase !== 2'd0)    begin tests_failed++; $display("FAIL reset_phase got %0d want 0", phase); end
    if (busy !== 1'b0)     begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    if (seq_done !== 1'b0) begin tests_failed++; $display("FAIL reset_seq_done got %b want 0", seq_done); end
    if (fault !== 1'b0)    begin tests_failed++; $display("FAIL reset_fault got %b want 0", fault); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_nominal();
    int pulses = 0;
    tim_en = 1'b1;
    start_seq();
    for (int k = 0; k <= 70; k++) begin
      @(negedge clock);
      if (seq_done === 1'b1) pulses++;
      case (k)
        0, 10, 20: begin
          tests_run += 2;
          if (enable !== 1'b1) begin tests_failed++; $display("FAIL nom_en_p0 k=%0d got %b want 1", k, enable); end
          if (phase !== 2'd0)  begin tests_failed++; $display("FAIL nom_phase0 k=%0d got %0d want 0", k, phase); end
        end
        21, 43: begin
          tests_run += 3;
          if (enable !== 1'b0) begin tests_failed++; $display("FAIL nom_gap_en k=%0d got %b want 0", k, enable); end
          if (busy !== 1'b1)   begin tests_failed++; $display("FAIL nom_gap_busy k=%0d got %b want 1", k, busy); end
          if (phase !== ((k == 21) ? 2'd1 : 2'd2))
            begin tests_failed++; $display("FAIL nom_gap_phase k=%0d got %0d", k, phase); end
        end
        22, 44, 64: begin
          tests_run += 2;
          if (enable !== 1'b1) begin tests_failed++; $display("FAIL nom_run_en k=%0d got %b want 1", k, enable); end
          if (phase !== ((k == 22) ? 2'd1 : 2'd2))
            begin tests_failed++; $display("FAIL nom_run_phase k=%0d got %0d", k, phase); end
        end
        65: begin
          tests_run += 4;
          if (seq_done !== 1'b1) begin tests_failed++; $display("FAIL nom_seq_done got %b want 1", seq_done); end
          if (busy !== 1'b0)     begin tests_failed++; $display("FAIL nom_busy_fall got %b want 0", busy); end
          if (phase !== 2'd0)    begin tests_failed++; $display("FAIL nom_phase_ret got %0d want 0", phase); end
          if (enable !== 1'b0)   begin tests_failed++; $display("FAIL nom_end_en got %b want 0", enable); end
        end
        66: begin
          tests_run++;
          if (seq_done !== 1'b0) begin tests_failed++; $display("FAIL nom_seq_done_width got %b want 0", seq_done); end
        end
        default: ;
      endcase
    end
    tests_run++;
    if (pulses !== 1) begin tests_failed++; $display("FAIL nom_pulse_count got %0d want 1", pulses); end
    tim_en = 1'b0;
  endtask

  task automatic test_abort();
    int pulses = 0;
    tim_en = 1'b1;
    start_seq();
    repeat (31) @(negedge clock);
    tests_run++;
    if (phase !== 2'd1) begin tests_failed++; $display("FAIL abort_pre_phase got %0d want 1", phase); end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    if (seq_done === 1'b1) pulses++;
    tests_run += 3;
    if (enable !== 1'b0) begin tests_failed++; $display("FAIL abort_enable got %b want 0", enable); end
    if (phase !== 2'd0)  begin tests_failed++; $display("FAIL abort_phase got %0d want 0", phase); end
    if (busy !== 1'b0)   begin tests_failed++; $display("FAIL abort_busy got %b want 0", busy); end
    repeat (60) begin
      @(negedge clock);
      if (seq_done === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL abort_no_seq_done got %0d want 0", pulses); end
    tim_en = 1'b0;
  endtask

  task automatic test_held_done();
    start_seq();
    repeat (3) @(negedge clock);
    done_force = 1'b1;
    @(negedge clock);
    tests_run++;
    if (phase !== 2'd1) begin tests_failed++; $display("FAIL held_first_adv got %0d want 1", phase); end
    repeat (4) @(negedge clock);
    done_force = 1'b0;
    repeat (5) @(negedge clock);
    tests_run += 3;
    if (phase !== 2'd1)  begin tests_failed++; $display("FAIL held_single_adv got %0d want 1", phase); end
    if (enable !== 1'b1) begin tests_failed++; $display("FAIL held_enable got %b want 1", enable); end
    if (busy !== 1'b1)   begin tests_failed++; $display("FAIL held_busy got %b want 1", busy); end
    do_abort();
  endtask

  task automatic test_simultaneous();
    start_seq();
    repeat (2) @(negedge clock);
    done_force = 1'b1;
    @(negedge clock);
    done_force = 1'b0;
    repeat (3) @(negedge clock);
    done_force = 1'b1;
    @(negedge clock);
    done_force = 1'b0;
    tests_run++;
    if (phase !== 2'd2) begin tests_failed++; $display("FAIL sim_reach_last got %0d want 2", phase); end
    repeat (3) @(negedge clock);
    done_force = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    done_force = 1'b0;
    abort = 1'b0;
    tests_run += 4;
    if (seq_done !== 1'b0) begin tests_failed++; $display("FAIL sim_abort_seq_done got %b want 0", seq_done); end
    if (busy !== 1'b0)     begin tests_failed++; $display("FAIL sim_abort_busy got %b want 0", busy); end
    if (phase !== 2'd0)    begin tests_failed++; $display("FAIL sim_abort_phase got %0d want 0", phase); end
    if (enable !== 1'b0)   begin tests_failed++; $display("FAIL sim_abort_enable got %b want 0", enable); end

    start_seq();
    repeat (2) @(negedge clock);
    done_force = 1'b1;
    @(negedge clock);
    done_force = 1'b0;
    repeat (2) @(negedge clock);
    start = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    tests_run += 3;
    if (phase !== 2'd1)  begin tests_failed++; $display("FAIL sim_start_busy_phase got %0d want 1", phase); end
    if (busy !== 1'b1)   begin tests_failed++; $display("FAIL sim_start_busy_busy got %b want 1", busy); end
    if (enable !== 1'b1) begin tests_failed++; $display("FAIL sim_start_busy_en got %b want 1", enable); end
    do_abort();
  endtask

  task automatic test_watchdog();
    start_seq();
    for (int k = 0; k <= 60; k++) begin
      @(negedge clock);
      if (k == 49) begin
        tests_run += 2;
        if (enable !== 1'b1) begin tests_failed++; $display("FAIL wd_pre_enable got %b want 1", enable); end
        if (fault !== 1'b0)  begin tests_failed++; $display("FAIL wd_pre_fault got %b want 0", fault); end
      end
      if (k == 50 || k == 60) begin
        tests_run += 3;
`ifdef PHASE_SEQ_WATCHDOG_EN
        if (fault !== 1'b1)  begin tests_failed++; $display("FAIL wd_fault k=%0d got %b want 1", k, fault); end
        if (enable !== 1'b0) begin tests_failed++; $display("FAIL wd_enable k=%0d got %b want 0", k, enable); end
`else
        if (fault !== 1'b0)  begin tests_failed++; $display("FAIL wd_fault k=%0d got %b want 0", k, fault); end
        if (enable !== 1'b1) begin tests_failed++; $display("FAIL wd_enable k=%0d got %b want 1", k, enable); end
`endif
        if (busy !== 1'b1)   begin tests_failed++; $display("FAIL wd_busy k=%0d got %b want 1", k, busy); end
      end
    end
    do_abort();
    tests_run += 3;
    if (fault !== 1'b0)  begin tests_failed++; $display("FAIL wd_abort_fault got %b want 0", fault); end
    if (busy !== 1'b0)   begin tests_failed++; $display("FAIL wd_abort_busy got %b want 0", busy); end
    if (enable !== 1'b0) begin tests_failed++; $display("FAIL wd_abort_enable got %b want 0", enable); end
  endtask

  task automatic test_async_reset();
    tim_en = 1'b1;
    start_seq();
    repeat (51) @(negedge clock);
    tests_run++;
    if (phase !== 2'd2) begin tests_failed++; $display("FAIL arst_pre_phase got %0d want 2", phase); end
    #2 reset_n = 1'b0;
    #1;
    tests_run += 5;
    if (enable !== 1'b0)   begin tests_failed++; $display("FAIL arst_enable got %b want 0", enable); end
    if (phase !== 2'd0)    begin tests_failed++; $display("FAIL arst_phase got %0d want 0", phase); end
    if (busy !== 1'b0)     begin tests_failed++; $display("FAIL arst_busy got %b want 0", busy); end
    if (seq_done !== 1'b0) begin tests_failed++; $display("FAIL arst_seq_done got %b want 0", seq_done); end
    if (fault !== 1'b0)    begin tests_failed++; $display("FAIL arst_fault got %b want 0", fault); end
    tim_en = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_abort();
    test_held_done();
    test_simultaneous();
    test_watchdog();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Controller-side counterpart of the 2-second interval timer: drives the timer's `enable`, consumes its `done_signal`, and steps through `NUM_PHASES` timed phases per started sequence. It sits between the top-level control logic and the timer. It restarts the timer cleanly for each phase and reports sequence completion, abort and (optionally) a stuck-timer fault.

## Interface
- `NUM_PHASES`, default 4: phases per sequence; legal range 2..16.
- `PHASE_W`, default `$clog2(NUM_PHASES)`: width of `phase`.
- `WDOG_CYCLES`, default 210_000_000: watchdog limit in clock cycles; fits in 28 bits.
- `clock`  in  1  system clock, 100 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled only in IDLE; begins a sequence.
- `abort`  in  1  level; returns the block to IDLE from any state.
- `done_signal`  in  1  expiry indication from the timer; each 0->1 transition is one expiry event.
- `enable`  out  1  timer enable; the timer counts while this is high.
- `phase`  out  PHASE_W  current phase index.
- `busy`  out  1  high in RUN, GAP and FAULT.
- `seq_done`  out  1  one-cycle pulse when the last phase expires.
- `fault`  out  1  watchdog fault; tied 0 when the watchdog is compiled out.

## Operation
- States: IDLE, RUN, GAP, FAULT. FAULT exists only with the watchdog macro.
- Expiry event: `done_signal` is high and `done_q` is low, where `done_q` is `done_signal` registered. `done_q` updates every cycle in every state.
- IDLE: `enable`=0, `phase`=0.
  - `start`=1 -> RUN.
- RUN: `enable`=1.
  - On an expiry event with `phase`==NUM_PHASES-1 -> IDLE, `seq_done` pulses, `phase` returns to 0.
  - On an expiry event otherwise -> GAP, `phase` increments.
- GAP: `enable`=0 for exactly one cycle so the timer counter restarts from zero, then -> RUN.
- Expiry events in IDLE, GAP or FAULT are discarded.
- `start` is ignored outside IDLE.
- `abort` has priority over `start`, expiry and watchdog.
  - From any non-IDLE state -> IDLE, `phase`=0, no `seq_done`.
  - From FAULT it also clears `fault`.
- `phase` never wraps. It reaches NUM_PHASES-1 at most and then returns to 0 only via IDLE.

## Timing
- All outputs are registered. Reset values: `enable`=0, `phase`=0, `busy`=0, `seq_done`=0, `fault`=0, state=IDLE, `done_q`=0, watchdog count=0.
- `start` sampled at edge N -> `enable`=1 and `busy`=1 from N+1.
- Expiry event sampled at edge N:
  - `enable`=0 and `phase` updated from N+1.
  - For a non-final phase, `enable`=1 again from N+2.
- Final expiry sampled at edge N -> `seq_done`=1 during cycle N+1 only; `busy`=0 from N+1.
- `abort` sampled at edge N -> IDLE outputs from N+1.
- Reset assertion mid-sequence forces reset values immediately, without waiting for a clock edge.
- A `done_signal` held high produces one event only. A new event requires a low cycle first.

## Configuration
- Macro: `PHASE_SEQ_WATCHDOG_EN`.
- Defined:
  - A 28-bit counter clears on entry to RUN and on every expiry event, and increments each RUN cycle.
  - When it reaches WDOG_CYCLES-1 without an event -> FAULT: `enable`=0, `fault`=1, `busy`=1.
  - FAULT is left only by `abort` or reset.
- Undefined: no counter and no FAULT state; `fault` is constant 0.

## Structure
- Package `phase_seq_pkg` holds:
  - the state enum typedef (`phase_seq_state_t`);
  - `DEFAULT_NUM_PHASES`;
  - `DEFAULT_WDOG_CYCLES`;
  - the watchdog counter width constant (28).
- One sub-module, `rise_detect`: holds the `done_q` flop and produces the one-cycle event. It has its own async active-low reset.
- The FSM, phase counter and watchdog live in `phase_sequencer`.

## Test plan
Bench setup: NUM_PHASES=3 and WDOG_CYCLES=50. A timer model raises `done_signal` for one cycle after 20 consecutive `enable`-high cycles.
- Nominal sequence: `start` pulse.
  - `phase` goes 0,1,2 with a one-cycle `enable` low at each transition.
  - `seq_done` pulses once, 1 cycle after the third event.
  - `busy` falls in the same cycle.
- Abort: `abort` during phase 1 -> next cycle `enable`=0, `phase`=0, `busy`=0, no `seq_done`.
- Held done: `done_signal` held high for 5 cycles in RUN phase 0 -> exactly one advance, to phase 1.
- Simultaneous inputs: `abort` and an expiry event in the same cycle -> IDLE, no `seq_done`. `start` while busy -> no effect on `phase`.
- Watchdog (macro defined): the model never raises `done_signal` -> `fault`=1 and `enable`=0 after 50 RUN cycles; `abort` -> `fault`=0, IDLE. Same stimulus with the macro undefined -> `fault` stays 0 and the block stays in RUN.
- Async reset: `reset_n` low mid-phase 2, off the clock edge -> all outputs read 0 before the next clock edge.
